// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out one byte
// plus odd parity and stop bit on device falling edges, then check the device ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int START_TIMEOUT  = 750000,
   parameter int FRAME_TIMEOUT  = 100000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] err_code,
   output logic [2:0] o_dbg_state
);

   localparam int MAX_A  = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
   localparam int MAX_C  = (MAX_A > FRAME_TIMEOUT) ? MAX_A : FRAME_TIMEOUT;
   localparam int CW     = $clog2(MAX_C + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_WAIT_FIRST, S_SEND, S_ACK, S_WAIT_IDLE, S_ERROR
   } state_t;

   state_t        r_state;
   logic          r_cmd_ready, r_busy, r_done, r_error;
   logic [1:0]    r_err_code;
   logic          r_clk_oe, r_dat_oe;
   logic [CW-1:0] r_timer;
   logic [3:0]    r_bitcnt;
   logic [7:0]    r_data;
   logic          r_parity;

   logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic [1:0]    r_clk_h, r_dat_h;
   logic          r_clk_f, r_dat_f, r_clk_fp;
   logic          w_clk_fall;
   logic          w_frame_to;

   // 2-FF synchroniser, then the filtered value only moves after 3 equal samples
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
         r_clk_h  <= 2'b11;
         r_dat_h  <= 2'b11;
         r_clk_f  <= 1'b1;
         r_dat_f  <= 1'b1;
         r_clk_fp <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk_in;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_dat_in;
         r_dat_s2 <= r_dat_s1;
         r_clk_h  <= {r_clk_h[0], r_clk_s2};
         r_dat_h  <= {r_dat_h[0], r_dat_s2};
         if (r_clk_s2 == r_clk_h[0] && r_clk_h[0] == r_clk_h[1]) r_clk_f <= r_clk_s2;
         if (r_dat_s2 == r_dat_h[0] && r_dat_h[0] == r_dat_h[1]) r_dat_f <= r_dat_s2;
         r_clk_fp <= r_clk_f;
      end
   end

   assign w_clk_fall = r_clk_fp & ~r_clk_f;
   assign w_frame_to = (r_timer == CW'(FRAME_TIMEOUT - 1));

   // Handshake: a byte transfers on a rising clock edge where cmd_valid and cmd_ready are both 1.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_err_code  <= 2'b00;
         r_clk_oe    <= 1'b0;
         r_dat_oe    <= 1'b0;
         r_timer     <= '0;
         r_bitcnt    <= 4'd0;
         r_data      <= 8'd0;
         r_parity    <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_data      <= cmd_data;
                  r_parity    <= ~^cmd_data;
                  r_err_code  <= 2'b00;
                  r_busy      <= 1'b1;
                  r_cmd_ready <= 1'b0;
                  r_clk_oe    <= 1'b1;
                  r_timer     <= '0;
                  r_state     <= S_INHIBIT;
               end
            end
            S_INHIBIT: begin
               if (r_timer == CW'(INHIBIT_CYCLES - 1)) begin
                  r_dat_oe <= 1'b1;
                  r_state  <= S_RTS;
               end else begin
                  r_timer <= r_timer + CW'(1);
               end
            end
            S_RTS: begin
               r_clk_oe <= 1'b0;
               r_timer  <= '0;
               r_state  <= S_WAIT_FIRST;
            end
            S_WAIT_FIRST: begin
               if (w_clk_fall) begin
                  r_dat_oe <= ~r_data[0];
                  r_bitcnt <= 4'd1;
                  r_timer  <= '0;
                  r_state  <= S_SEND;
               end else if (r_timer == CW'(START_TIMEOUT - 1)) begin
                  r_err_code <= 2'b01;
                  r_dat_oe   <= 1'b0;
                  r_clk_oe   <= 1'b0;
                  r_state    <= S_ERROR;
               end else begin
                  r_timer <= r_timer + CW'(1);
               end
            end
            S_SEND, S_ACK, S_WAIT_IDLE: begin
               if (w_frame_to) begin
                  r_err_code <= 2'b10;
                  r_dat_oe   <= 1'b0;
                  r_clk_oe   <= 1'b0;
                  r_state    <= S_ERROR;
               end else begin
                  r_timer <= r_timer + CW'(1);
                  if (r_state == S_SEND && w_clk_fall) begin
                     r_bitcnt <= r_bitcnt + 4'd1;
                     if (r_bitcnt == 4'd9) begin
                        r_dat_oe <= 1'b0;
                        r_state  <= S_ACK;
                     end else if (r_bitcnt == 4'd8) begin
                        r_dat_oe <= ~r_parity;
                     end else begin
                        r_dat_oe <= ~r_data[r_bitcnt[2:0]];
                     end
                  end else if (r_state == S_ACK && w_clk_fall) begin
                     if (!r_dat_f) begin
                        r_state <= S_WAIT_IDLE;
                     end else begin
                        r_err_code <= 2'b11;
                        r_dat_oe   <= 1'b0;
                        r_clk_oe   <= 1'b0;
                        r_state    <= S_ERROR;
                     end
                  end else if (r_state == S_WAIT_IDLE && r_clk_f && r_dat_f) begin
                     r_done      <= 1'b1;
                     r_busy      <= 1'b0;
                     r_cmd_ready <= 1'b1;
                     r_state     <= S_IDLE;
                  end
               end
            end
            S_ERROR: begin
               r_error     <= 1'b1;
               r_busy      <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign busy        = r_busy;
   assign done        = r_done;
   assign error       = r_error;
   assign err_code    = r_err_code;
   assign ps2_clk_oe  = r_clk_oe;
   assign ps2_dat_oe  = r_dat_oe;
   assign o_dbg_state = r_state;

endmodule
